// File: rtl/text_terminal_writer_pkg.sv
// Shared definitions for the text terminal writer: control codes, FSM state,
// write-position source select and a width helper.
package text_terminal_writer_pkg;

  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_FF = 8'h0C;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Which counter supplies the registered write position.
  typedef enum logic [1:0] {
    SRC_CURSOR = 2'd0,
    SRC_BACK   = 2'd1,
    SRC_SWEEP  = 2'd2
  } wr_src_t;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cursor_counter.sv
// 2-D column/row position counter with home, carriage-return, line-feed,
// step-back-in-row and increment operations (priority in that order).
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   home_i         go to (0,0)
//   cr_i           x = 0
//   lf_i           x = 0, y + 1 (row wraps)
//   back_i         x - 1 when x > 0, otherwise no change
//   inc_i          advance one cell; end-of-row behaviour set by WRAP_EN
//   x_o, y_o       current position
//   nx_o, ny_o     position after this cycle's operation
module cursor_counter
  import text_terminal_writer_pkg::*;
#(
  parameter int unsigned COLS    = 12,
  parameter int unsigned ROWS    = 2,
  parameter bit          WRAP_EN = 1'b1,
  parameter int unsigned XW      = clog2_min1(COLS),
  parameter int unsigned YW      = clog2_min1(ROWS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          home_i,
  input  logic          cr_i,
  input  logic          lf_i,
  input  logic          back_i,
  input  logic          inc_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [XW-1:0] nx_o,
  output logic [YW-1:0] ny_o
);

  // Explicit end limits: dimensions need not be powers of two.
  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [YW-1:0] y_step;

  // Next row with wrap to the top (no scrolling).
  assign y_step = (y_q == Y_MAX) ? '0 : y_q + YW'(1);

  // Next position from the highest-priority requested operation.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (home_i) begin
      x_d = '0;
      y_d = '0;
    end else if (cr_i) begin
      x_d = '0;
    end else if (lf_i) begin
      x_d = '0;
      y_d = y_step;
    end else if (back_i) begin
      if (x_q != '0) x_d = x_q - XW'(1);
    end else if (inc_i) begin
      if (x_q != X_MAX) begin
        x_d = x_q + XW'(1);
      end else if (WRAP_EN) begin
        x_d = '0;
        y_d = y_step;
      end
    end
  end

  // Position register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o  = x_q;
  assign y_o  = y_q;
  assign nx_o = x_d;
  assign ny_o = y_d;

endmodule

// File: rtl/text_terminal_writer.sv
// Text terminal writer: converts a byte stream into character-table writes,
// tracking a cursor, interpreting CR/LF/BS/FF and sweeping a screen clear.
//
// Build option: define TEXT_TERMINAL_AUTOWRAP_EN to wrap the cursor to the
// next row after the last column; otherwise printables stick at the last
// column until CR, LF or clear.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_char, i_char_dv, o_ready   character input handshake (o_ready is comb)
//   i_clear                      one-cycle clear-screen request
//   o_wr_en, o_wr_character,
//   o_wr_x_pos, o_wr_y_pos       registered character-table write port
//   o_cursor_x, o_cursor_y       current cursor position
//   o_busy                       clear sweep in progress
module text_terminal_writer
  import text_terminal_writer_pkg::*;
#(
  parameter int unsigned CHAR_BUFF_COLUMNS = 12,
  parameter int unsigned CHAR_BUFF_ROWS    = 2,
  parameter int unsigned FONT_NUM_CHAR     = 256,
  parameter logic [7:0]  BLANK_CHAR        = 8'h20,
  localparam int unsigned CW = clog2_min1(FONT_NUM_CHAR),
  localparam int unsigned XW = clog2_min1(CHAR_BUFF_COLUMNS),
  localparam int unsigned YW = clog2_min1(CHAR_BUFF_ROWS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [CW-1:0] i_char,
  input  logic          i_char_dv,
  output logic          o_ready,
  input  logic          i_clear,
  output logic          o_wr_en,
  output logic [CW-1:0] o_wr_character,
  output logic [XW-1:0] o_wr_x_pos,
  output logic [YW-1:0] o_wr_y_pos,
  output logic [XW-1:0] o_cursor_x,
  output logic [YW-1:0] o_cursor_y,
  output logic          o_busy
);

`ifdef TEXT_TERMINAL_AUTOWRAP_EN
  localparam bit AUTOWRAP = 1'b1;
`else
  localparam bit AUTOWRAP = 1'b0;
`endif

  localparam logic [XW-1:0] X_MAX   = XW'(CHAR_BUFF_COLUMNS - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(CHAR_BUFF_ROWS - 1);
  localparam logic [CW-1:0] BLANK   = CW'(BLANK_CHAR);
  localparam logic [CW-1:0] CODE_BS = CW'(CHAR_BS);
  localparam logic [CW-1:0] CODE_LF = CW'(CHAR_LF);
  localparam logic [CW-1:0] CODE_FF = CW'(CHAR_FF);
  localparam logic [CW-1:0] CODE_CR = CW'(CHAR_CR);

  state_t        state_q, state_d;
  logic          wr_en_q, wr_en_d;
  logic [CW-1:0] wr_char_q, wr_char_d;
  logic [XW-1:0] wr_x_q, wr_x_d;
  logic [YW-1:0] wr_y_q, wr_y_d;
  wr_src_t       wr_src;

  logic          accept;
  logic          is_bs, is_lf, is_ff, is_cr;
  logic          sweep_last;

  logic          cur_home, cur_cr, cur_lf, cur_back, cur_inc;
  logic [XW-1:0] cur_x, cur_nx;
  logic [YW-1:0] cur_y, cur_ny;

  logic          sw_home, sw_inc;
  logic [XW-1:0] sw_x, sw_nx;
  logic [YW-1:0] sw_y, sw_ny;

  // Reset is included so nothing is offered while held in reset.
  assign o_ready = (state_q == IDLE) && !i_clear && !i_rst;
  assign accept  = i_char_dv && o_ready;

  assign is_bs = (i_char == CODE_BS);
  assign is_lf = (i_char == CODE_LF);
  assign is_ff = (i_char == CODE_FF);
  assign is_cr = (i_char == CODE_CR);

  assign sweep_last = (sw_x == X_MAX) && (sw_y == Y_MAX);

  // Cursor position.
  cursor_counter #(
    .COLS    (CHAR_BUFF_COLUMNS),
    .ROWS    (CHAR_BUFF_ROWS),
    .WRAP_EN (AUTOWRAP)
  ) u_cursor (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .home_i (cur_home),
    .cr_i   (cur_cr),
    .lf_i   (cur_lf),
    .back_i (cur_back),
    .inc_i  (cur_inc),
    .x_o    (cur_x),
    .y_o    (cur_y),
    .nx_o   (cur_nx),
    .ny_o   (cur_ny)
  );

  // Clear-sweep position: holds the cell currently being blanked.
  cursor_counter #(
    .COLS    (CHAR_BUFF_COLUMNS),
    .ROWS    (CHAR_BUFF_ROWS),
    .WRAP_EN (1'b1)
  ) u_sweep (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .home_i (sw_home),
    .cr_i   (1'b0),
    .lf_i   (1'b0),
    .back_i (1'b0),
    .inc_i  (sw_inc),
    .x_o    (sw_x),
    .y_o    (sw_y),
    .nx_o   (sw_nx),
    .ny_o   (sw_ny)
  );

  // Next state, counter operations and write request.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_char_d = BLANK;
    wr_src    = SRC_CURSOR;
    cur_home  = 1'b0;
    cur_cr    = 1'b0;
    cur_lf    = 1'b0;
    cur_back  = 1'b0;
    cur_inc   = 1'b0;
    sw_home   = 1'b0;
    sw_inc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // i_clear blocks o_ready, so a same-cycle character is never taken.
        if (i_clear || (accept && is_ff)) begin
          state_d = CLEAR;
          sw_home = 1'b1;
          wr_en_d = 1'b1;
          wr_src  = SRC_SWEEP;
        end else if (accept) begin
          if (is_cr) begin
            cur_cr = 1'b1;
          end else if (is_lf) begin
            cur_lf = 1'b1;
          end else if (is_bs) begin
            if (cur_x != '0) begin
              cur_back = 1'b1;
              wr_en_d  = 1'b1;
              wr_src   = SRC_BACK;
            end
          end else begin
            cur_inc   = 1'b1;
            wr_en_d   = 1'b1;
            wr_char_d = i_char;
          end
        end
      end

      CLEAR: begin
        if (sweep_last) begin
          state_d  = IDLE;
          cur_home = 1'b1;
        end else begin
          sw_inc  = 1'b1;
          wr_en_d = 1'b1;
          wr_src  = SRC_SWEEP;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Write position select.
  always_comb begin
    wr_x_d = cur_x;
    wr_y_d = cur_y;
    unique case (wr_src)
      SRC_BACK: begin
        wr_x_d = cur_nx;
        wr_y_d = cur_ny;
      end
      SRC_SWEEP: begin
        wr_x_d = sw_nx;
        wr_y_d = sw_ny;
      end
      default: begin
        wr_x_d = cur_x;
        wr_y_d = cur_y;
      end
    endcase
  end

  // State and write-port registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_char_q <= '0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_char_q <= wr_char_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
    end
  end

  assign o_wr_en        = wr_en_q;
  assign o_wr_character = wr_char_q;
  assign o_wr_x_pos     = wr_x_q;
  assign o_wr_y_pos     = wr_y_q;
  assign o_cursor_x     = cur_x;
  assign o_cursor_y     = cur_y;
  assign o_busy         = (state_q == CLEAR);

endmodule

// File: tb/tb_text_terminal_writer.sv
// Directed self-checking bench for text_terminal_writer (12x2 table).
module tb_text_terminal_writer;

  logic       clk;
  logic       rst;
  logic [7:0] i_char;
  logic       i_char_dv;
  logic       o_ready;
  logic       i_clear;
  logic       o_wr_en;
  logic [7:0] o_wr_character;
  logic [3:0] o_wr_x_pos;
  logic [0:0] o_wr_y_pos;
  logic [3:0] o_cursor_x;
  logic [0:0] o_cursor_y;
  logic       o_busy;

  int tests;
  int fails;

  text_terminal_writer #(
    .CHAR_BUFF_COLUMNS (12),
    .CHAR_BUFF_ROWS    (2),
    .FONT_NUM_CHAR     (256),
    .BLANK_CHAR        (8'h20)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_char         (i_char),
    .i_char_dv      (i_char_dv),
    .o_ready        (o_ready),
    .i_clear        (i_clear),
    .o_wr_en        (o_wr_en),
    .o_wr_character (o_wr_character),
    .o_wr_x_pos     (o_wr_x_pos),
    .o_wr_y_pos     (o_wr_y_pos),
    .o_cursor_x     (o_cursor_x),
    .o_cursor_y     (o_cursor_y),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle accept; returns #1 into the cycle that carries the write.
  task automatic send(input logic [7:0] c);
    i_char    = c;
    i_char_dv = 1'b1;
    step();
    i_char_dv = 1'b0;
  endtask

  task automatic expect_wr(input string tag, input logic [7:0] c, input int x, input int y);
    check({tag, "_en"}, 32'(o_wr_en), 32'd1);
    check({tag, "_ch"}, 32'(o_wr_character), 32'(c));
    check({tag, "_x"},  32'(o_wr_x_pos), 32'(x));
    check({tag, "_y"},  32'(o_wr_y_pos), 32'(y));
  endtask

  task automatic expect_nowr(input string tag);
    check({tag, "_nowr"}, 32'(o_wr_en), 32'd0);
  endtask

  task automatic expect_cur(input string tag, input int x, input int y);
    check({tag, "_cx"}, 32'(o_cursor_x), 32'(x));
    check({tag, "_cy"}, 32'(o_cursor_y), 32'(y));
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    i_char    = 8'h00;
    i_char_dv = 1'b0;
    i_clear   = 1'b0;

    // Reset state
    step();
    step();
    expect_nowr("rst");
    check("rst_busy", 32'(o_busy), 32'd0);
    expect_cur("rst", 0, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);

    // Back-to-back 'A','B'
    i_char    = "A";
    i_char_dv = 1'b1;
    step();
    i_char = "B";
    expect_wr("wrA", "A", 0, 0);
    expect_cur("wrA", 1, 0);
    step();
    i_char_dv = 1'b0;
    expect_wr("wrB", "B", 1, 0);
    expect_cur("wrB", 2, 0);
    step();
    expect_nowr("idle1");

    // Fill row 0 up to the last column, then end-of-line behaviour
    for (int i = 0; i < 9; i++) send(8'(8'h61 + i));
    expect_cur("fill", 11, 0);
    send("L");
    expect_wr("wrL", "L", 11, 0);
`ifdef TEXT_TERMINAL_AUTOWRAP_EN
    expect_cur("eol", 0, 1);
    send("Z");
    expect_wr("wrZ", "Z", 0, 1);
    expect_cur("afterZ", 1, 1);
    send(8'h0D);
`else
    expect_cur("eol", 11, 0);
    send("Z");
    expect_wr("wrZ", "Z", 11, 0);
    expect_cur("afterZ", 11, 0);
    send(8'h0A);
`endif
    expect_nowr("nl1");
    expect_cur("nl1", 0, 1);

    // Bottom-right cell
    for (int i = 0; i < 11; i++) send(8'(8'h30 + i));
    expect_cur("fill1", 11, 1);
    send("Q");
    expect_wr("wrQ", "Q", 11, 1);
`ifdef TEXT_TERMINAL_AUTOWRAP_EN
    expect_cur("afterQ", 0, 0);
    send(8'h0A);
`else
    expect_cur("afterQ", 11, 1);
    send(8'h0D);
`endif
    expect_cur("nl2", 0, 1);

    // Backspace / CR
    send("x");
    send("y");
    send("z");
    expect_cur("at3", 3, 1);
    send(8'h08);
    expect_wr("bs1", 8'h20, 2, 1);
    expect_cur("bs1", 2, 1);
    send(8'h0D);
    expect_nowr("cr");
    expect_cur("cr", 0, 1);
    send(8'h08);
    expect_nowr("bs0");
    expect_cur("bs0", 0, 1);
    send(8'h0A);
    expect_nowr("lfwrap");
    expect_cur("lfwrap", 0, 0);
    send("m");
    expect_cur("m", 1, 0);

    // Clear racing a character; a second clear mid-sweep is ignored
    i_char    = "X";
    i_char_dv = 1'b1;
    i_clear   = 1'b1;
    #1;
    check("clr_ready", 32'(o_ready), 32'd0);
    step();
    i_char_dv = 1'b0;
    i_clear   = 1'b0;
    for (int i = 0; i < 24; i++) begin
      expect_wr($sformatf("sw%0d", i), 8'h20, i % 12, i / 12);
      check($sformatf("sw%0d_busy", i), 32'(o_busy), 32'd1);
      check($sformatf("sw%0d_rdy", i), 32'(o_ready), 32'd0);
      i_clear = (i == 5);
      step();
      i_clear = 1'b0;
    end
    expect_nowr("swdone");
    check("swdone_busy", 32'(o_busy), 32'd0);
    check("swdone_rdy", 32'(o_ready), 32'd1);
    expect_cur("swdone", 0, 0);
    step();
    expect_nowr("swidle");

    // FF-triggered clear, aborted by reset after 10 writes
    send("k");
    expect_wr("wrk", "k", 0, 0);
    send(8'h0C);
    expect_wr("ff0", 8'h20, 0, 0);
    check("ff0_busy", 32'(o_busy), 32'd1);
    expect_cur("ff0", 1, 0);
    repeat (9) step();
    expect_wr("ff9", 8'h20, 9, 0);
    rst = 1'b1;
    #1;
    expect_nowr("abort");
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_ch", 32'(o_wr_character), 32'd0);
    check("abort_x", 32'(o_wr_x_pos), 32'd0);
    expect_cur("abort", 0, 0);
    step();
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(o_ready), 32'd1);
    send("R");
    expect_wr("wrR", "R", 0, 0);
    expect_cur("wrR", 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/text_terminal_writer.md
Name: text_terminal_writer

Overview:
- Upstream stage of the font/character-table renderer: turns a byte stream (e.g. UART RX or a test sequencer) into character-table writes.
- Tracks a cursor, handles control codes (CR, LF, BS, FF) and performs a full-screen clear sweep.
- Drives the renderer's write port (`i_wr_en`, `i_wr_character`, `i_wr_x_pos`, `i_wr_y_pos`) directly.

Parameters:
- CHAR_BUFF_COLUMNS, 12, character columns in the table.
- CHAR_BUFF_ROWS, 2, character rows in the table.
- FONT_NUM_CHAR, 256, font size; sets character code width CW = $clog2(FONT_NUM_CHAR).
- BLANK_CHAR, 8'h20, code written by clear and backspace.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_char  in  CW  incoming character code.
- i_char_dv  in  1  i_char valid.
- o_ready  out  1  block can accept i_char this cycle.
- i_clear  in  1  one-cycle request to clear screen and home the cursor.
- o_wr_en  out  1  character-table write strobe.
- o_wr_character  out  CW  code to write.
- o_wr_x_pos  out  $clog2(CHAR_BUFF_COLUMNS)  write column.
- o_wr_y_pos  out  $clog2(CHAR_BUFF_ROWS)  write row.
- o_cursor_x  out  $clog2(CHAR_BUFF_COLUMNS)  current cursor column.
- o_cursor_y  out  $clog2(CHAR_BUFF_ROWS)  current cursor row.
- o_busy  out  1  clear sweep in progress.

Behaviour:
- Reset (async, i_rst=1): state=IDLE; all outputs 0 except o_ready=1 once i_rst deasserts. Cursor (0,0). Reset mid-sweep aborts the sweep and leaves the table partially cleared.
- States:
  - IDLE: accepts characters.
  - CLEAR: sweeps every cell, one per cycle.
- Handshake:
  - o_ready = (state==IDLE) && !i_clear, combinational.
  - Accept occurs when i_char_dv && o_ready at a rising edge.
  - Back-to-back accepts run at 1 per cycle.
- Write latency: for an accepted printable code, o_wr_en=1 in the cycle after the accept edge, with o_wr_character=code and position = cursor value before the accept. o_wr_en is a single-cycle pulse per write.
- Printable = any code other than 0x08, 0x0A, 0x0C, 0x0D. After the write, the cursor advances:
  - x+1 when x < COLS-1.
  - At x = COLS-1: x=0, y+1.
  - At y = ROWS-1 the row wraps to 0. There is no scrolling.
- 0x0D (CR): x=0; no write.
- 0x0A (LF): x=0, y+1 with the same row wrap; no write.
- 0x08 (BS):
  - x>0: x-1, then write BLANK_CHAR at the new position, same latency as printable.
  - x=0: no effect, no write. It does not move to the previous row.
- 0x0C (FF): identical to i_clear.
- Clear:
  - Triggered by i_clear in IDLE, or an accepted FF. Enter CLEAR; o_busy=1, o_ready=0.
  - The sweep counter (x,y) runs from (0,0) in row-major order to (COLS-1,ROWS-1).
  - One o_wr_en pulse of BLANK_CHAR per cycle, so COLS*ROWS writes in consecutive cycles. The first write appears the cycle after the trigger edge.
  - After the last write: cursor=(0,0), return to IDLE, o_busy=0 in the cycle following the last write.
- Simultaneous events:
  - i_clear and i_char_dv in the same cycle: the clear wins and the character is not accepted (o_ready=0).
  - i_clear asserted while already in CLEAR is ignored.
  - i_char_dv while o_ready=0 is ignored; the source must hold it.
- Arithmetic: the cursor and sweep counters are compared against COLS-1 and ROWS-1 explicitly. They must not rely on power-of-two overflow.

Optional Feature:
- Macro: TEXT_TERMINAL_AUTOWRAP_EN.
- Defined: end-of-line behaviour as above (x wraps to 0, y+1).
- Undefined: at x=COLS-1 a printable write leaves the cursor at COLS-1, so subsequent printables overwrite the last column until CR, LF or clear. BS and the other control codes are unchanged.

Decomposition:
- Shared package: control-code constants CHAR_BS=8'h08, CHAR_LF=8'h0A, CHAR_FF=8'h0C, CHAR_CR=8'h0D, plus the state enum typedef (IDLE, CLEAR).
- One natural sub-module: `cursor_counter`, a 2-D column/row counter with inc, home and step-back-in-row operations. It is instantiated twice, once for the cursor and once for the clear sweep.

Test Plan:
- Reset then send 'A','B' back-to-back → writes ('A',0,0) and ('B',1,0) on consecutive cycles; cursor ends at (2,0).
- Send 12 printables, then 'Z' → the 12th is written at (11,0) and 'Z' at (0,1). With the macro undefined, 'Z' is written at (11,0) instead.
- Cursor at (11,1), send 'Q' → write at (11,1); cursor wraps to (0,0).
- Cursor at (3,1): send BS → write (0x20,2,1), cursor (2,1). Then CR → cursor (0,1), no write. Then BS → no write, cursor unchanged.
- Pulse i_clear with i_char_dv='X' in the same cycle → 'X' is not accepted; 24 consecutive writes of 0x20 from (0,0) to (11,1); o_busy high for exactly 24 cycles; cursor (0,0); o_ready returns to 1.
- Assert i_rst after 10 cycles of the sweep → all outputs 0 immediately; cursor (0,0); after release, a new char is written at (0,0).
